gravity_timer: RTL
==================

# gravity_timer

Consumer-side timing block for the Tetris game logic. Runs on the fast system clock and replaces free-running divided clocks with one-cycle enables. Produces a level-dependent gravity request (`drop_req`) with a req/ack handshake to the piece-movement FSM, plus pause and soft-drop support. All outputs are synchronous to `Clk`; no derived clocks leave the block.

## Interface
- `PRESCALE`, 50000: `Clk` cycles per base tick (1 ms at 50 MHz).
- `LEVEL_W`, 4: width of `level`.
- `BASE_PERIOD`, 800: base ticks per drop at level 0.
- `STEP`, 50: base ticks removed per level.
- `MIN_PERIOD`, 50: floor on the gravity period.
- `SOFT_PERIOD`, 40: period while soft drop is active.
- `Clk` in 1: system clock. The block has one clock.
- `Reset` in 1: synchronous, active-high reset.
- `run` in 1: game active. Low forces IDLE.
- `pause` in 1: level-sensitive freeze.
- `level` in LEVEL_W: current level, sampled at every base tick.
- `soft_drop` in 1: player holds the down key.
- `drop_ack` in 1: movement FSM has consumed the request.
- `drop_req` out 1: gravity request, held until acknowledged.
- `base_tick` out 1: one-cycle strobe, once every `PRESCALE` cycles, while in RUN.
- `state` out 2: current FSM state, for debug and HUD.

## Operation
- States (encoded in the package): IDLE=0, RUN=1, WAIT=2, PAUSED=3.
- **IDLE**
  - Prescaler and interval counter are held at 0; `drop_req` is 0.
  - When `run`=1, the FSM moves to RUN.
- **RUN**
  - The prescaler counts 0..PRESCALE-1. At wrap it pulses `base_tick`.
  - On each `base_tick` the interval counter increments.
  - When the interval counter is at or above period-1 on a `base_tick`, the counter clears, `drop_req` is set, and the FSM moves to WAIT.
- **WAIT**
  - `drop_req`=1. The prescaler and interval counter are held at 0.
  - On `drop_ack`=1: `drop_req` clears and the FSM returns to RUN.
  - `drop_ack` sampled outside WAIT is ignored.
- **PAUSED**
  - Entered from RUN or WAIT when `pause`=1.
  - Counters are frozen. `drop_req` is forced to 0, but a pending flag remembers whether the FSM came from WAIT.
  - When `pause`=0, the FSM returns to WAIT if pending, otherwise to RUN, with counters resumed exactly where they stopped.
- **Period arithmetic** (16-bit unsigned):
  - period = BASE_PERIOD − level·STEP.
  - If level·STEP ≥ BASE_PERIOD − MIN_PERIOD, period saturates to MIN_PERIOD.
  - With soft drop active, period = min(period, SOFT_PERIOD).
  - The period is recomputed at every `base_tick`. Lowering the period below the current count fires on the next `base_tick`.
- **Priorities**, highest first: `Reset`, then `run`=0 (go to IDLE and clear everything), then `drop_ack` in WAIT, then `pause`.
  - `drop_ack` and `pause` in the same WAIT cycle: pending clears, then the FSM enters PAUSED with resume to RUN.
  - Interval completion and `pause` in the same cycle: completion is recorded as pending, and the FSM enters PAUSED.

## Timing
- On `Reset`: `drop_req`=0, `base_tick`=0, `state`=IDLE, all counters 0.
- All outputs are registered.
- `run` sampled high in cycle n: `state`=RUN in cycle n+1.
- Let cycle 1 be the first RUN cycle. With constant inputs, `base_tick` is high in cycles k·PRESCALE for k ≥ 1.
- `drop_req` rises at cycle period·PRESCALE+1, the cycle after the completing `base_tick`.
- `drop_ack` sampled high in cycle m: `drop_req`=0 and `state`=RUN in cycle m+1. The next drop follows a full period·PRESCALE cycles later.
- `pause` takes effect in the cycle after it is sampled. The frozen cycle count is not added to the interval.

## Configuration
- Macro: `GRAVITY_TIMER_SOFT_DROP_EN`.
- Defined: `soft_drop` applies SOFT_PERIOD as described in Operation.
- Undefined: `soft_drop` is ignored (port kept, input unused). Period depends on `level` only.

## Structure
- Package `tetris_timing_pkg` holds:
  - the state enum `gt_state_e`;
  - the 16-bit period type `period_t`;
  - default period constants shared with the HUD speed display.
- Sub-module `tick_prescaler` contains the `PRESCALE` counter with an enable (RUN only) and a `base_tick` strobe. It is reusable for animation timing.
- The FSM, period computation and handshake stay in `gravity_timer`.

## Test plan
All scenarios use PRESCALE=4, BASE_PERIOD=10, STEP=2, MIN_PERIOD=3, SOFT_PERIOD=2.
- Basic drop: `Reset`, then `run`=1, level=0 → `drop_req` rises 40 cycles after the first RUN cycle. With `drop_ack` held high, it recurs every 41 cycles (40 cycles plus one ack cycle).
- Handshake hold: delay `drop_ack` by 25 cycles → `drop_req` stays high the whole time. No `base_tick` occurs and the interval counter stays 0 while waiting.
- Level saturation: level=4 gives period 3 (12 cycles). Level=15 also gives 3, with no wrap to a huge period.
- Soft drop: level=0 with `soft_drop`=1 → period 2 (8 cycles) with the macro defined. Period 10 (40 cycles) with it undefined.
- Pause: assert `pause` 20 cycles into RUN for 100 cycles → `drop_req` rises 20 cycles after release. Pausing during WAIT drops `drop_req` and restores it on release.
- Abort: `run`=0 during WAIT, then `Reset` mid-RUN → `state`=IDLE, `drop_req`=0 next cycle. A restart produces the full 40-cycle latency.

Source files
------------

// File: rtl/gravity_timer_pkg.sv
// tetris_timing_pkg: shared timing definitions for the Tetris game logic.
//   gt_state_e  - gravity timer FSM state encoding (also shown on the HUD)
//   period_t    - 16-bit unsigned gravity period, in base ticks
//   DEF_*       - default timing constants, shared with the HUD speed display
//   calc_period - level/soft-drop to gravity period mapping
package tetris_timing_pkg;

  typedef enum logic [1:0] {
    GT_IDLE   = 2'd0,
    GT_RUN    = 2'd1,
    GT_WAIT   = 2'd2,
    GT_PAUSED = 2'd3
  } gt_state_e;

  typedef logic [15:0] period_t;

  localparam int DEF_PRESCALE    = 50000;
  localparam int DEF_LEVEL_W     = 4;
  localparam int DEF_BASE_PERIOD = 800;
  localparam int DEF_STEP        = 50;
  localparam int DEF_MIN_PERIOD  = 50;
  localparam int DEF_SOFT_PERIOD = 40;

  // Saturating period: once level*step would push the period below the
  // floor, the floor is used. The comparison is done on the product so a
  // high level never wraps the subtraction into a huge period.
  function automatic period_t calc_period(
    input period_t level_val,
    input period_t base,
    input period_t step,
    input period_t min_p,
    input period_t soft_p,
    input logic    soft_on
  );
    period_t prod;
    period_t p;
    prod = level_val * step;
    if (prod >= base - min_p) p = min_p;
    else                      p = base - prod;
    if (soft_on && (soft_p < p)) p = soft_p;
    return p;
  endfunction

endpackage

// File: rtl/gravity_timer_tick_prescaler.sv
// tick_prescaler: divides the system clock into a one-cycle tick enable.
// Reusable for any slow game timing (gravity, animation).
// Ports:
//   clk   in  - system clock
//   reset in  - synchronous active-high reset
//   en    in  - advance the counter this cycle
//   clr   in  - force counter to 0 (takes precedence over en)
//   tick  out - registered strobe, high in the cycle after the counter wraps
// PRESCALE must be at least 1.
module tick_prescaler #(
  parameter int PRESCALE = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt;

  // The owner drives en for the cycle it is about to spend running, so the
  // count always equals the number of enabled cycles modulo PRESCALE and
  // tick lands exactly on every PRESCALE-th enabled cycle.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (en) begin
      if (cnt == LAST) begin
        cnt  <= '0;
        tick <= 1'b1;
      end else begin
        cnt  <= cnt + 1'b1;
        tick <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/gravity_timer.sv
// gravity_timer: level-dependent gravity request generator with req/ack
// handshake to the piece-movement FSM, pause and soft-drop support.
// Optional feature macro: GRAVITY_TIMER_SOFT_DROP_EN (soft_drop shortens the
// period to SOFT_PERIOD; when undefined soft_drop is ignored).
// Ports:
//   Clk       in  - system clock (only clock)
//   Reset     in  - synchronous active-high reset
//   run       in  - game active; low forces IDLE
//   pause     in  - level-sensitive freeze
//   level     in  - current level, sampled on each base tick
//   soft_drop in  - player holds the down key
//   drop_ack  in  - movement FSM consumed the request (WAIT only)
//   drop_req  out - gravity request, held until acknowledged
//   base_tick out - one-cycle strobe every PRESCALE RUN cycles
//   state     out - current FSM state (gt_state_e encoding)
module gravity_timer
  import tetris_timing_pkg::*;
#(
  parameter int PRESCALE    = DEF_PRESCALE,
  parameter int LEVEL_W     = DEF_LEVEL_W,
  parameter int BASE_PERIOD = DEF_BASE_PERIOD,
  parameter int STEP        = DEF_STEP,
  parameter int MIN_PERIOD  = DEF_MIN_PERIOD,
  parameter int SOFT_PERIOD = DEF_SOFT_PERIOD
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               run,
  input  logic               pause,
  input  logic [LEVEL_W-1:0] level,
  input  logic               soft_drop,
  input  logic               drop_ack,
  output logic               drop_req,
  output logic               base_tick,
  output logic [1:0]         state
);

  localparam period_t BASE_P = period_t'(BASE_PERIOD);
  localparam period_t STEP_P = period_t'(STEP);
  localparam period_t MIN_P  = period_t'(MIN_PERIOD);
  localparam period_t SOFT_P = period_t'(SOFT_PERIOD);

  gt_state_e state_q;
  gt_state_e state_next;
  period_t   interval_cnt;
  period_t   period;
  logic      pending;
  logic      complete;
  logic      soft_on;

`ifdef GRAVITY_TIMER_SOFT_DROP_EN
  assign soft_on = soft_drop;
`else
  logic unused_soft;
  assign soft_on     = 1'b0;
  assign unused_soft = soft_drop;
`endif

  assign period   = calc_period(period_t'(level), BASE_P, STEP_P, MIN_P, SOFT_P, soft_on);
  // count+1 >= period, widened so a zero period cannot wrap the compare
  assign complete = base_tick && (({1'b0, interval_cnt} + 17'd1) >= {1'b0, period});
  assign state    = state_q;

  // Next state is needed by the prescaler enable so that the prescaler only
  // advances on cycles actually spent in RUN; a paused or waiting cycle never
  // contributes to the interval.
  always_comb begin
    state_next = state_q;
    case (state_q)
      GT_IDLE:   state_next = GT_RUN;
      GT_RUN: begin
        if (pause)         state_next = GT_PAUSED;
        else if (complete) state_next = GT_WAIT;
      end
      GT_WAIT: begin
        if (drop_ack)   state_next = pause ? GT_PAUSED : GT_RUN;
        else if (pause) state_next = GT_PAUSED;
      end
      GT_PAUSED: begin
        if (!pause) state_next = pending ? GT_WAIT : GT_RUN;
      end
      default:   state_next = GT_IDLE;
    endcase
    if (!run) state_next = GT_IDLE;
  end

  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (Clk),
    .reset (Reset),
    .en    (state_next == GT_RUN),
    .clr   ((state_next == GT_IDLE) || (state_next == GT_WAIT)),
    .tick  (base_tick)
  );

  // FSM register plus interval counter, request and pending flag. A
  // completion that coincides with pause is parked in pending so the request
  // reappears when the pause is released.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= GT_IDLE;
      drop_req     <= 1'b0;
      pending      <= 1'b0;
      interval_cnt <= '0;
    end else begin
      state_q <= state_next;
      if (!run) begin
        drop_req     <= 1'b0;
        pending      <= 1'b0;
        interval_cnt <= '0;
      end else begin
        case (state_q)
          GT_IDLE: begin
            drop_req     <= 1'b0;
            pending      <= 1'b0;
            interval_cnt <= '0;
          end
          GT_RUN: begin
            if (base_tick) begin
              if (complete) begin
                interval_cnt <= '0;
                if (pause) pending  <= 1'b1;
                else       drop_req <= 1'b1;
              end else begin
                interval_cnt <= interval_cnt + 16'd1;
              end
            end
          end
          GT_WAIT: begin
            if (drop_ack) begin
              drop_req <= 1'b0;
              pending  <= 1'b0;
            end else if (pause) begin
              drop_req <= 1'b0;
              pending  <= 1'b1;
            end
          end
          GT_PAUSED: begin
            if (!pause) begin
              drop_req <= pending;
              pending  <= 1'b0;
            end
          end
          default: begin
            drop_req <= 1'b0;
            pending  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
